// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Recovers the 5-bit digit code from an observed seven-segment bus. A new
//   pattern must be sampled identically on STABLE_CYCLES+1 consecutive edges
//   before it is accepted. Each accepted pattern is reported exactly once.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   segments_in  observed segment bus (bit7=dp, bit6..0=g..a)
//   value        last accepted digit code (bit4=dp, bits3..0=hex digit)
//   valid        one-cycle pulse: legal digit accepted
//   blank        level: last accepted pattern had all segments off
//   error        one-cycle pulse: illegal pattern accepted
//   err_count    saturating count of accepted illegal patterns
module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] segments_in,
  output logic [4:0] value,
  output logic       valid,
  output logic       blank,
  output logic       error,
  output logic [7:0] err_count
);

  localparam int unsigned SEG_W = 8;
  localparam int unsigned VAL_W = 5;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic {
    ST_SETTLING = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               blank_q, blank_d;
  logic               error_q, error_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [DIG_W-1:0]   dec_digit;
  logic               dec_legal;
  logic               dec_blank;

  // Segment pattern (g..a) to hex digit; anything off-table is illegal.
  always_comb begin
    dec_digit = '0;
    dec_legal = 1'b1;
    dec_blank = (seg_q[6:0] == 7'h00);
    case (seg_q[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Settle tracking and accept handling.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    blank_d     = blank_q;
    error_d     = 1'b0;
    err_count_d = err_count_q;

    if (segments_in != seg_q) begin
      // Any change restarts the settle, whichever state we were in.
      seg_d   = segments_in;
      cnt_d   = CNT_W'(1);
      state_d = ST_SETTLING;
    end else if (state_q == ST_SETTLING) begin
      if (cnt_q >= CNT_TARGET) begin
        state_d = ST_LOCKED;
        if (dec_blank) begin
          blank_d = 1'b1;
        end else if (dec_legal) begin
          value_d = {seg_q[7], dec_digit};
          valid_d = 1'b1;
          blank_d = 1'b0;
        end else begin
          error_d = 1'b1;
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOCKED;
      seg_q       <= '0;
      cnt_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      blank_q     <= 1'b1;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign blank     = blank_q;
  assign error     = error_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder with a scoreboard of expected
// reports (pushed when a pattern is driven, popped when a pulse appears).
module tb_seven_segment_decoder;

  localparam int S = 4;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;
  localparam int K_BLANK = 3;

  typedef struct {
    logic       is_err;
    logic [4:0] value;
    logic       blank;
    logic [7:0] err_count;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] segments_in;
  logic [4:0] value;
  logic       valid;
  logic       blank;
  logic       error;
  logic [7:0] err_count;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  logic [4:0] value_m   = 5'd0;
  logic       blank_m   = 1'b1;
  logic [7:0] err_m     = 8'd0;

  seven_segment_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .segments_in (segments_in),
    .value       (value),
    .valid       (valid),
    .blank       (blank),
    .error       (error),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a pattern at a negedge, record what it should produce, hold it.
  task automatic drive(input logic [7:0] pat, input int hold, input int kind,
                       input logic [4:0] v);
    exp_t e;
    segments_in = pat;
    case (kind)
      K_VALID: begin
        value_m = v;
        blank_m = 1'b0;
        e = '{1'b0, value_m, blank_m, err_m, cyc + 1 + S};
        sb.push_back(e);
      end
      K_ERR: begin
        if (err_m != 8'hFF) err_m = err_m + 8'd1;
        e = '{1'b1, value_m, blank_m, err_m, cyc + 1 + S};
        sb.push_back(e);
      end
      K_BLANK: blank_m = 1'b1;
      default: ;
    endcase
    repeat (hold) @(negedge clk);
  endtask

  // Every pulse must match the oldest outstanding expected report.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (valid || error)) begin
      check("pulse_excl", 32'(valid & error), 32'd0);
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pulse_kind_error", 32'(error), 32'(e.is_err));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_value", 32'(value), 32'(e.value));
        check("pulse_blank", 32'(blank), 32'(e.blank));
        check("pulse_err_count", 32'(err_count), 32'(e.err_count));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    segments_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Quiet bus after reset: reset values hold, nothing reported.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", 32'({value, blank, valid, error, err_count}),
            32'({5'd0, 1'b1, 1'b0, 1'b0, 8'd0}));
    end

    // Single report for a long hold; dp carried into bit4.
    drive(8'h7F, 30, K_VALID, 5'h08);
    check("hold_8_value", 32'({value, blank}), 32'({5'h08, 1'b0}));
    drive(8'hF1, 10, K_VALID, 5'h1F);
    check("dp_F_value", 32'(value), 32'h1F);

    // Short glitch never reported.
    drive(8'h06, 3, K_NONE, 5'h0);
    drive(8'h5B, 10, K_VALID, 5'h02);
    check("glitch_value", 32'(value), 32'h02);

    // Same pattern re-reported after an unaccepted intervening pattern.
    drive(8'h3F, 10, K_VALID, 5'h00);
    drive(8'h06, 1, K_NONE, 5'h0);
    drive(8'h3F, 10, K_VALID, 5'h00);
    check("rereport_value", 32'(value), 32'h00);

    // Illegal pattern leaves value alone and bumps the counter.
    drive(8'h66, 6, K_VALID, 5'h04);
    drive(8'h49, 10, K_ERR, 5'h0);
    check("illegal_first", 32'({value, blank, err_count}), 32'({5'h04, 1'b0, 8'd1}));
    for (int i = 0; i < 300; i++) begin
      drive(8'h00, 5, K_BLANK, 5'h0);
      drive(8'h49, 5, K_ERR, 5'h0);
    end
    check("err_saturate", 32'(err_count), 32'd255);
    check("err_value_kept", 32'(value), 32'h04);

    // Blank with dp only: blank level, value kept, no pulse.
    drive(8'h6F, 6, K_VALID, 5'h09);
    check("pre_blank", 32'(blank), 32'd0);
    drive(8'h80, 8, K_BLANK, 5'h0);
    check("blank_dp", 32'({value, blank}), 32'({5'h09, 1'b1}));

    // Reset during a settle aborts it silently.
    drive(8'h6D, 2, K_NONE, 5'h0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_settle", 32'({value, blank, valid, error, err_count}),
          32'({5'd0, 1'b1, 1'b0, 1'b0, 8'd0}));
    segments_in = 8'h00;
    value_m = 5'd0;
    blank_m = 1'b1;
    err_m   = 8'd0;
    reset   = 1'b0;
    repeat (10) @(negedge clk);
    check("after_reset_quiet", 32'({value, blank, err_count}), 32'({5'd0, 1'b1, 8'd0}));

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Inverse of the team's seven-segment encoder: samples an 8-bit segment bus (bit0=a … bit6=g, bit7=dp) and recovers the 5-bit value, with bit4 = decimal point.
- Filters glitches: a pattern is decoded only after it has been stable for STABLE_CYCLES clocks.
- Each stable pattern is reported exactly once.
- Used for loopback self-test of the display path and for reading an external multiplexed display.

Parameters:
STABLE_CYCLES, 4, consecutive clocks a new pattern must hold before it is decoded; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
segments_in  input  8  segment bus under observation (bit7=dp, bit6..0=g..a)
value  output  5  last accepted digit code; bit4=dp, bits3..0=hex digit
valid  output  1  one-cycle pulse when a legal digit pattern is accepted
blank  output  1  level: last accepted pattern was blank
error  output  1  one-cycle pulse when an illegal pattern is accepted
err_count  output  8  count of illegal patterns accepted, saturating

Behaviour:
- Reset: the synchronous active-high reset sets:
  - value=0, valid=0, blank=1, error=0, err_count=0
  - internal seg_q=8'h00, cnt=0, state=LOCKED
- Reset asserted mid-settle aborts the settle with no pulse.
- A constant 8'h00 input after reset produces no report.
- States: SETTLING, LOCKED. Each edge, with reset low:
  - segments_in != seg_q: seg_q<=segments_in, cnt<=1, state<=SETTLING, no report. This applies in either state, and a change always restarts the count.
  - segments_in == seg_q and state==SETTLING and cnt==STABLE_CYCLES: accept seg_q and go to LOCKED.
  - segments_in == seg_q and state==SETTLING and cnt<STABLE_CYCLES: cnt<=cnt+1.
  - LOCKED with an unchanged input: hold, no outputs change except that valid/error deassert.
- Latency: an input presented before edge k and held through edge k+STABLE_CYCLES is reported at the outputs after edge k+STABLE_CYCLES. The input must be sampled identical on STABLE_CYCLES+1 edges.
- Decode on accept, using bits6..0 of seg_q (encoder table):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
- Accept outcomes, exactly one per accept:
  - Legal digit: value<={seg_q[7],digit}; valid=1 for one cycle; blank<=0.
  - Blank (bits6..0 == 0, so 8'h00 or 8'h80): blank<=1; value unchanged; no valid, no error.
  - Illegal (anything else): error=1 for one cycle; err_count<=err_count+1, saturating at 255; value and blank unchanged.
- Re-reporting: the same pattern is reported again only after an intervening different pattern has been sampled, even if that pattern was never accepted.
- valid and error are registered; they never assert together and never on consecutive cycles.
- cnt is wide enough to hold STABLE_CYCLES and never wraps.
- STABLE_CYCLES=1: a pattern is reported after it has been sampled on 2 edges.

Test Plan:
1. Assert reset 2 cycles, drive 8'h00 for 20 cycles -> value=0, blank=1, valid=0, error=0, err_count=0 throughout.
2. Drive 8'h7F from edge k, hold 30 cycles (STABLE_CYCLES=4) -> single valid pulse after edge k+4, value=5'h08, blank=0; no further pulses. Then 8'hF1 -> value=5'h1F.
3. Glitch: 8'h06 for 3 edges, then 8'h5B held -> no report for 1; one valid pulse with value=5'h02, 4 edges after 8'h5B first sampled.
4. Sequence 8'h3F, 8'h06 held 1 cycle, 8'h3F held -> value=0 reported twice, each pulse preceded by the full settle; 8'h06 never reported.
5. Illegal 8'h49 held -> one error pulse, err_count=1, value unchanged. Alternate 8'h49/8'h00 each held ≥5 edges for 300 pairs -> err_count stops at 255.
6. 8'h80 held -> blank=1, no valid/error. Drive 8'h6D and assert reset at cnt=2 -> no pulse; outputs at reset values the cycle after.
